// File: rtl/prbs_chk.sv
// prbs_chk: receive-side checker for the 8-bit right-shift LFSR stream
// (feedback Q[7]^Q[3]^Q[2]^Q[1], serial output Q[0]).
// The checker hunts for 8 valid bits to fill its history, then predicts
// each following bit and counts mismatches in a saturating error counter.
//
// Optional feature macro: PRBS_CHK_AUTORESYNC_EN
//   defined   : LOSS_THR consecutive mismatches drop lock and restart the hunt
//   undefined : the consecutive-mismatch count saturates and lock is held until reset
//
// state | meaning
// ------+---------------------------------------------------------------
// HUNT  | filling history with received bits, fcnt counts valid bits
// CHECK | locked; history advances on predicted bits, mismatches counted

module prbs_chk #(
  parameter int n        = 8,
  parameter int LOSS_THR = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             NReset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int MCNT_W = $clog2(LOSS_THR + 1);

  typedef enum logic {
    HUNT  = 1'b0,
    CHECK = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [n-1:0]        h_q, h_d;
  logic [3:0]          fcnt_q, fcnt_d;
  logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic                pred;
  logic                miss;
  logic                cnt_inc;
  logic                unused_h_msb;

  // Prediction of the next bit from history (H[0] newest): b(t+8) = b(t+7)^b(t+3)^b(t+2)^b(t+1)
  assign pred = h_q[0] ^ h_q[4] ^ h_q[5] ^ h_q[6];
  assign miss = din ^ pred;

  // Oldest history bit only ages out; the fixed n=8 predictor never reads it.
  assign unused_h_msb = h_q[n-1];

  // Next-state logic for hunt/check sequencing, history and mismatch run length
  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    fcnt_d   = fcnt_q;
    mcnt_d   = mcnt_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    cnt_inc  = 1'b0;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          h_d = {h_q[n-2:0], din};
          if (fcnt_q == 4'(n - 1)) begin
            state_d  = CHECK;
            locked_d = 1'b1;
            fcnt_d   = '0;
          end else begin
            fcnt_d = fcnt_q + 4'd1;
          end
        end
        CHECK: begin
          // Shift in the prediction, not din, so a single flipped bit
          // cannot corrupt later predictions.
          h_d = {h_q[n-2:0], pred};
          if (miss) begin
            err_d   = 1'b1;
            cnt_inc = 1'b1;
`ifdef PRBS_CHK_AUTORESYNC_EN
            if (mcnt_q == MCNT_W'(LOSS_THR - 1)) begin
              state_d  = HUNT;
              locked_d = 1'b0;
              fcnt_d   = '0;
              mcnt_d   = '0;
            end else begin
              mcnt_d = mcnt_q + MCNT_W'(1);
            end
`else
            if (mcnt_q != MCNT_W'(LOSS_THR)) begin
              mcnt_d = mcnt_q + MCNT_W'(1);
            end
`endif
          end else begin
            mcnt_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Saturating error counter; clear wins over a simultaneous increment
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (cnt_inc && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge NReset) begin
    if (!NReset) begin
      state_q   <= HUNT;
      h_q       <= '0;
      fcnt_q    <= '0;
      mcnt_q    <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      fcnt_q    <= fcnt_d;
      mcnt_q    <= mcnt_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule
